// File: rtl/bp_be_retire_track_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_pkg
// Purpose  : Shared types for the backend retire tracker (FSM states and the
//            width-parameterised pipeline slot struct).
// Revision : 1.0  initial release
// ============================================================================

// The slot widths come from module parameters, so the struct is stamped out
// inside each user through this macro instead of living in the package.
`define BP_BE_DECLARE_RETIRE_SLOT_S(exc_w, spc_w) \
    typedef struct packed {                        \
        logic              v;                      \
        logic              qv;                     \
        logic [exc_w-1:0]  exc;                    \
        logic [spc_w-1:0]  spc;                    \
    } bp_be_retire_slot_s

`define BP_BE_RETIRE_SLOT_WIDTH(exc_w, spc_w) (2 + (exc_w) + (spc_w))

package bp_be_pkg;

    typedef enum logic [1:0] {
        e_run   = 2'd0,
        e_drain = 2'd1,
        e_wfi   = 2'd2
    } bp_be_retire_track_state_e;

    // Wide enough for drain_cycles_p up to 7.
    localparam int c_drain_cnt_w = 3;

endpackage

`default_nettype wire

// File: rtl/bp_be_retire_track_slot.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_retire_track_slot
// Purpose  : One pipeline slot register with load and kill control; kill
//            empties the slot and takes priority over load.
// Revision : 1.0  initial release
// ============================================================================

module bp_be_retire_track_slot #(
    parameter int exception_width_p = 16,
    parameter int special_width_p   = 8,
    parameter int slot_width_p      = `BP_BE_RETIRE_SLOT_WIDTH(exception_width_p, special_width_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    load_i,
    input  logic                    kill_i,
    input  logic [slot_width_p-1:0] data_i,
    output logic [slot_width_p-1:0] data_o
);

    logic [slot_width_p-1:0] r_data;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data <= '0;
        end else if (kill_i) begin
            r_data <= '0;
        end else if (load_i) begin
            r_data <= data_i;
        end
    end

    assign data_o = r_data;

endmodule

`default_nettype wire

// File: rtl/bp_be_retire_track.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_retire_track
// Purpose  : Follows issued ops through ex1/ex2, accumulates exception and
//            special flags, presents the retire bundle two cycles after issue
//            and blocks issue during post-exception drain and WFI.
//            Optional statistics counters: BP_BE_RETIRE_TRACK_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================

module bp_be_retire_track
    import bp_be_pkg::*;
#(
    parameter int exception_width_p = 16,
    parameter int special_width_p   = 8,
    parameter int wfi_idx_p         = 0,
    parameter int drain_cycles_p    = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         issue_v_i,
    input  logic                         issue_queue_v_i,
    output logic                         issue_ready_o,
    input  logic [exception_width_p-1:0] ex1_exception_i,
    input  logic [special_width_p-1:0]   ex1_special_i,
    input  logic [exception_width_p-1:0] ex2_exception_i,
    input  logic [special_width_p-1:0]   ex2_special_i,
    input  logic                         flush_i,
    input  logic                         irq_waiting_i,
    output logic                         retire_v_o,
    output logic                         retire_queue_v_o,
    output logic [exception_width_p-1:0] retire_exception_o,
    output logic [special_width_p-1:0]   retire_special_o
`ifdef BP_BE_RETIRE_TRACK_STATS_EN
   ,output logic [31:0]                  instret_cnt_o,
    output logic [31:0]                  exc_cnt_o,
    output logic [31:0]                  drain_cnt_o
`endif
);

    `BP_BE_DECLARE_RETIRE_SLOT_S(exception_width_p, special_width_p);

    localparam int c_slot_w = `BP_BE_RETIRE_SLOT_WIDTH(exception_width_p, special_width_p);
    localparam logic [c_drain_cnt_w-1:0] c_drain_init = c_drain_cnt_w'(drain_cycles_p - 1);
    localparam logic [c_drain_cnt_w-1:0] c_drain_one  = c_drain_cnt_w'(1);

    bp_be_retire_slot_s w_ex1_d, w_ex1_q;
    bp_be_retire_slot_s w_ex2_d, w_ex2_q;

    bp_be_retire_track_state_e r_state, w_state_next;
    logic [c_drain_cnt_w-1:0]  r_drain_cnt, w_drain_cnt_next;
    logic                      r_ready_en;

    logic w_has_exc;
    logic w_has_spc;
    logic w_is_wfi;

    // ------------------------------------------------------------------
    // Slot pipeline; flags raised in ex1 belong to the ex1 occupant
    // ------------------------------------------------------------------
    always_comb begin
        w_ex1_d    = '0;
        w_ex1_d.v  = issue_v_i & issue_ready_o;
        w_ex1_d.qv = issue_queue_v_i;

        w_ex2_d    = '0;
        w_ex2_d.v  = w_ex1_q.v;
        w_ex2_d.qv = w_ex1_q.qv;
        if (w_ex1_q.v) begin
            w_ex2_d.exc = w_ex1_q.exc | ex1_exception_i;
            w_ex2_d.spc = w_ex1_q.spc | ex1_special_i;
        end
    end

    bp_be_retire_track_slot #(
        .exception_width_p (exception_width_p),
        .special_width_p   (special_width_p),
        .slot_width_p      (c_slot_w)
    ) u_ex1_slot (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (1'b1),
        .kill_i    (flush_i),
        .data_i    (w_ex1_d),
        .data_o    (w_ex1_q)
    );

    // The ex2 occupant caused any flush, so only its successor is killed.
    bp_be_retire_track_slot #(
        .exception_width_p (exception_width_p),
        .special_width_p   (special_width_p),
        .slot_width_p      (c_slot_w)
    ) u_ex2_slot (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (1'b1),
        .kill_i    (flush_i),
        .data_i    (w_ex2_d),
        .data_o    (w_ex2_q)
    );

    assign retire_v_o         = w_ex2_q.v;
    assign retire_queue_v_o   = w_ex2_q.v & w_ex2_q.qv;
    assign retire_exception_o = w_ex2_q.v ? (w_ex2_q.exc | ex2_exception_i) : '0;
    assign retire_special_o   = w_ex2_q.v ? (w_ex2_q.spc | ex2_special_i) : '0;

    assign w_has_exc = |retire_exception_o;
    assign w_has_spc = |retire_special_o;
    assign w_is_wfi  = retire_special_o[wfi_idx_p];

    // ------------------------------------------------------------------
    // Issue-blocking FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= e_run;
            r_drain_cnt <= '0;
            r_ready_en  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_ready_en  <= 1'b1;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        case (r_state)
            e_run: begin
                // Exception outranks WFI; a WFI mixed with other specials still sleeps.
                if (retire_v_o) begin
                    if (w_has_exc) begin
                        w_state_next     = e_drain;
                        w_drain_cnt_next = c_drain_init;
                    end else if (w_is_wfi) begin
                        w_state_next = e_wfi;
                    end else if (w_has_spc) begin
                        w_state_next     = e_drain;
                        w_drain_cnt_next = c_drain_init;
                    end
                end
            end
            e_drain: begin
                if (r_drain_cnt == '0) begin
                    w_state_next = e_run;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - c_drain_one;
                end
            end
            e_wfi: begin
                if (irq_waiting_i || flush_i) begin
                    w_state_next = e_run;
                end
            end
            default: begin
                w_state_next     = e_run;
                w_drain_cnt_next = '0;
            end
        endcase
    end

    // Held low for the first edge after reset release.
    assign issue_ready_o = r_ready_en & (r_state == e_run);

`ifdef BP_BE_RETIRE_TRACK_STATS_EN
    logic [31:0] r_instret_cnt;
    logic [31:0] r_exc_cnt;
    logic [31:0] r_drain_stat_cnt;
    logic        w_instret_inc;
    logic        w_exc_inc;
    logic        w_drain_inc;

    assign w_instret_inc = retire_queue_v_o & ~w_has_exc;
    assign w_exc_inc     = retire_v_o & w_has_exc;
    assign w_drain_inc   = (r_state == e_drain) | (r_state == e_wfi);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_instret_cnt    <= '0;
            r_exc_cnt        <= '0;
            r_drain_stat_cnt <= '0;
        end else begin
            if (w_instret_inc && (r_instret_cnt != '1)) r_instret_cnt <= r_instret_cnt + 32'd1;
            if (w_exc_inc && (r_exc_cnt != '1))         r_exc_cnt     <= r_exc_cnt + 32'd1;
            if (w_drain_inc && (r_drain_stat_cnt != '1)) r_drain_stat_cnt <= r_drain_stat_cnt + 32'd1;
        end
    end

    assign instret_cnt_o = r_instret_cnt;
    assign exc_cnt_o     = r_exc_cnt;
    assign drain_cnt_o   = r_drain_stat_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_be_retire_track.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_be_retire_track
// Purpose  : Directed bench for bp_be_retire_track with a cycle-history model
//            and hand-computed literal checks.
// Revision : 1.0  initial release
// ============================================================================

module tb_bp_be_retire_track;

    localparam int c_drain = 2;
    localparam int c_wfi   = 0;
    localparam int c_hist  = 512;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        issue_v  = 1'b0;
    logic        issue_qv = 1'b0;
    logic        flush    = 1'b0;
    logic        irq      = 1'b0;
    logic [15:0] x1 = '0, x2 = '0;
    logic [7:0]  s1 = '0, s2 = '0;

    logic        ready;
    logic        retire_v;
    logic        retire_qv;
    logic [15:0] retire_exc;
    logic [7:0]  retire_spc;
`ifdef BP_BE_RETIRE_TRACK_STATS_EN
    logic [31:0] instret_cnt, exc_cnt, drain_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bp_be_retire_track #(
        .exception_width_p (16),
        .special_width_p   (8),
        .wfi_idx_p         (c_wfi),
        .drain_cycles_p    (c_drain)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .issue_v_i          (issue_v),
        .issue_queue_v_i    (issue_qv),
        .issue_ready_o      (ready),
        .ex1_exception_i    (x1),
        .ex1_special_i      (s1),
        .ex2_exception_i    (x2),
        .ex2_special_i      (s2),
        .flush_i            (flush),
        .irq_waiting_i      (irq),
        .retire_v_o         (retire_v),
        .retire_queue_v_o   (retire_qv),
        .retire_exception_o (retire_exc),
        .retire_special_o   (retire_spc)
`ifdef BP_BE_RETIRE_TRACK_STATS_EN
       ,.instret_cnt_o      (instret_cnt),
        .exc_cnt_o          (exc_cnt),
        .drain_cnt_o        (drain_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Model: per-cycle history of what was accepted/flushed/raised; a retire
    // at t is the op accepted at t-2 that was not flushed at t-1.
    bit         m_acc [c_hist];
    bit         m_qv  [c_hist];
    bit         m_fl  [c_hist];
    logic [15:0] m_x1 [c_hist];
    logic [7:0]  m_s1 [c_hist];
    int  m_block_until = 0;
    int  m_rst_ready   = 0;
    bit  m_wfi         = 1'b0;
    int  m_ninst = 0, m_nexc = 0, m_ndrain = 0;

    always @(negedge clk) begin
        logic        ev, eqv, erdy, in_run;
        logic [15:0] ex;
        logic [7:0]  es;
        if (!reset_n) begin
            chk("rst_retire_v", 32'(retire_v), 0);
            chk("rst_ready", 32'(ready), 0);
            chk("rst_exc", 32'(retire_exc), 0);
            m_acc[cyc] = 1'b0; m_fl[cyc] = 1'b0; m_qv[cyc] = 1'b0;
            m_x1[cyc] = '0; m_s1[cyc] = '0;
            m_rst_ready = cyc + 2;
            m_block_until = 0;
            m_wfi = 1'b0;
            m_ninst = 0; m_nexc = 0; m_ndrain = 0;
        end else begin
            ev  = (cyc >= 2) && m_acc[cyc-2] && !m_fl[cyc-1];
            eqv = ev && m_qv[cyc-2];
            ex  = ev ? (m_x1[cyc-1] | x2) : 16'h0;
            es  = ev ? (m_s1[cyc-1] | s2) : 8'h0;
            in_run = (cyc >= m_block_until) && !m_wfi;
            erdy   = in_run && (cyc >= m_rst_ready);

            chk("retire_v", 32'(retire_v), 32'(ev));
            chk("retire_queue_v", 32'(retire_qv), 32'(eqv));
            chk("retire_exception", 32'(retire_exc), 32'(ex));
            chk("retire_special", 32'(retire_spc), 32'(es));
            chk("issue_ready", 32'(ready), 32'(erdy));
`ifdef BP_BE_RETIRE_TRACK_STATS_EN
            chk("instret_cnt", instret_cnt, m_ninst);
            chk("exc_cnt", exc_cnt, m_nexc);
            chk("drain_cnt", drain_cnt, m_ndrain);
`endif
            m_acc[cyc] = issue_v && erdy && !flush;
            m_qv[cyc]  = issue_qv;
            m_fl[cyc]  = flush;
            m_x1[cyc]  = x1;
            m_s1[cyc]  = s1;

            if (eqv && ex == 0) m_ninst++;
            if (ev && ex != 0)  m_nexc++;
            if (!in_run)        m_ndrain++;

            if (m_wfi) begin
                if (irq || flush) m_wfi = 1'b0;
            end else if (in_run && ev) begin
                if (ex != 0)           m_block_until = cyc + c_drain + 1;
                else if (es[c_wfi])    m_wfi = 1'b1;
                else if (es != 0)      m_block_until = cyc + c_drain + 1;
            end
        end
        cyc++;
    end

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        for (int c = 0; c <= 130; c++) begin
            go(c);
            if (c == 103) begin
                chk("pre_rst_retire_v", 32'(retire_v), 1);
                chk("pre_rst_ready", 32'(ready), 0);
            end
            issue_v = 1'b0; issue_qv = 1'b0; flush = 1'b0; irq = 1'b0;
            x1 = '0; x2 = '0; s1 = '0; s2 = '0;
            reset_n = !((c <= 2) || (c >= 103 && c <= 105));
            case (c)
                10, 20, 30, 31, 40, 45, 56, 58, 60, 70, 80, 100,
                110, 111, 112, 113, 114, 115: begin issue_v = 1'b1; issue_qv = 1'b1; end
                55, 57, 59: begin issue_v = 1'b1; issue_qv = 1'b0; end
                21:  x1 = 16'h0004;
                22:  x2 = 16'h0010;
                32:  begin issue_v = 1'b1; issue_qv = 1'b1; flush = 1'b1; end
                41, 71: s1 = 8'h01;
                50:  irq = 1'b1;
                62:  s2 = 8'h80;
                75:  flush = 1'b1;
                81:  s1 = 8'h01;
                82:  x2 = 16'h0001;
                90:  begin x2 = 16'hffff; s2 = 8'hff; end
                101: begin issue_v = 1'b1; issue_qv = 1'b1; x1 = 16'h0002; end
                116: x1 = 16'h0100;
                default: ;
            endcase
            #1;
            case (c)
                1:   begin chk("lit_rst_ready", 32'(ready), 0); chk("lit_rst_v", 32'(retire_v), 0); end
                3:   chk("lit_ready_release", 32'(ready), 0);
                4:   chk("lit_ready_after", 32'(ready), 1);
                11:  chk("lit_v_c11", 32'(retire_v), 0);
                12:  begin
                         chk("lit_v_c12", 32'(retire_v), 1);
                         chk("lit_qv_c12", 32'(retire_qv), 1);
                         chk("lit_exc_c12", 32'(retire_exc), 0);
                     end
                13:  chk("lit_v_c13", 32'(retire_v), 0);
                22:  chk("lit_exc_accum", 32'(retire_exc), 32'h0014);
                23, 24: chk("lit_drain_ready", 32'(ready), 0);
                25:  chk("lit_drain_done", 32'(ready), 1);
                32:  chk("lit_flush_owner", 32'(retire_v), 1);
                33:  chk("lit_flush_killed", 32'(retire_v), 0);
                34:  chk("lit_flush_drop", 32'(retire_v), 0);
                42:  chk("lit_wfi_spc", 32'(retire_spc), 32'h01);
                47:  chk("lit_wfi_drop", 32'(retire_v), 0);
                50:  chk("lit_wfi_ready", 32'(ready), 0);
                51:  chk("lit_wfi_wake", 32'(ready), 1);
                57:  chk("lit_qv0", 32'(retire_qv), 0);
                65:  chk("lit_spc_drain_done", 32'(ready), 1);
                64:  chk("lit_spc_drain", 32'(ready), 0);
                76:  chk("lit_wfi_flush_wake", 32'(ready), 1);
                82:  chk("lit_exc_wfi_exc", 32'(retire_exc), 32'h0001);
                83:  chk("lit_exc_over_wfi", 32'(ready), 0);
                85:  chk("lit_exc_over_wfi_done", 32'(ready), 1);
                90:  chk("lit_invalid_ignored", 32'(retire_exc), 0);
                102: chk("lit_exc_c102", 32'(retire_exc), 32'h0002);
                103: begin
                         chk("lit_async_v", 32'(retire_v), 0);
                         chk("lit_async_ready", 32'(ready), 0);
                         chk("lit_async_spc", 32'(retire_spc), 0);
                     end
                106: chk("lit_rel_ready", 32'(ready), 0);
                107: chk("lit_rel_ready_after", 32'(ready), 1);
`ifdef BP_BE_RETIRE_TRACK_STATS_EN
                125: begin
                         chk("lit_instret", instret_cnt, 5);
                         chk("lit_exc_cnt", exc_cnt, 1);
                         chk("lit_drain_cnt", drain_cnt, 2);
                     end
`endif
                default: ;
            endcase
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
